// File: rtl/common_constants.sv
// common_constants: display-wide constants shared by the video pipeline blocks
package common_constants;
   localparam int XGA_VISIBLE_H       = 1024;
   localparam int XGA_VISIBLE_V       = 768;
   localparam int BURST_WORDS_DEFAULT = 32;
   localparam int PIXEL_WIDTH         = 24;
endpackage

// File: rtl/disp_pixel_buf_pkg.sv
// disp_pixel_buf_pkg: word geometry and defaults for the pixel buffer
package disp_pixel_buf_pkg;
   import common_constants::*;
   localparam int WORD_WIDTH         = 32;
   localparam int FIFO_DEPTH_DEFAULT = 64;
   localparam int BURST_BYTES        = BURST_WORDS_DEFAULT * WORD_WIDTH / 8;
   localparam int UNDERFLOW_CNT_W    = 16;
   typedef logic [WORD_WIDTH-1:0]  word_t;
   typedef logic [PIXEL_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/disp_fifo_ram.sv
// disp_fifo_ram: simple dual-port RAM, one write port and one registered read port
module disp_fifo_ram
   import disp_pixel_buf_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int WIDTH = WORD_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   // write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   // registered read port, holds its value when not enabled
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/disp_pixel_buf.sv
// disp_pixel_buf: AXI read-data to display pixel FIFO; DISP_PIXEL_BUF_UNDERFLOW_CNT_EN adds UNDERFLOW_CNT
module disp_pixel_buf
   import common_constants::*, disp_pixel_buf_pkg::*;
#(
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
   parameter int BURST_WORDS = BURST_WORDS_DEFAULT
) (
   input  logic                   ACLK,
   input  logic                   ARST,
   input  logic [WORD_WIDTH-1:0]  RDATA,
   input  logic                   RVALID,
   input  logic                   RREADY,
   output logic                   FIFO_READY,
   input  logic                   FRAME_START,
   input  logic                   PIX_REQ,
   output logic [PIXEL_WIDTH-1:0] PIX_RGB,
   output logic                   PIX_VALID,
   output logic                   UNDERFLOW
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
   ,
   output logic [UNDERFLOW_CNT_W-1:0] UNDERFLOW_CNT
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] BURST_C = (AW+1)'(BURST_WORDS);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          empty, full, push, pop, starve, zero_out;
   word_t         ram_q;
   logic          unused_ram_bits;
   // FRAME_START discards any push, pop or underflow in its own cycle
   always_comb begin
      empty  = count == '0;
      full   = count == DEPTH_C;
      push   = RVALID & RREADY & ~full & ~FRAME_START;
      pop    = PIX_REQ & ~empty & ~FRAME_START;
      starve = PIX_REQ & empty & ~FRAME_START;
   end
   // pointers and occupancy; power-of-two depth makes pointer wrap free
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (FRAME_START) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // burst-space flag, one cycle behind the occupancy
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) FIFO_READY <= 1'b0;
      else FIFO_READY <= (DEPTH_C - count) >= BURST_C;
   end
   // pixel strobe, sticky underflow, and forced-black after a starved request
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         PIX_VALID <= 1'b0;
         UNDERFLOW <= 1'b0;
         zero_out  <= 1'b1;
      end else begin
         PIX_VALID <= pop;
         UNDERFLOW <= ~FRAME_START & (UNDERFLOW | starve);
         zero_out  <= starve | (zero_out & ~pop);
      end
   end
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
   // saturating count of starved request cycles
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) UNDERFLOW_CNT <= '0;
      else if (FRAME_START) UNDERFLOW_CNT <= '0;
      else if (starve && UNDERFLOW_CNT != '1) UNDERFLOW_CNT <= UNDERFLOW_CNT + 1'b1;
   end
`endif
   // the RAM read register is the pixel register; zero_out masks it to black
   assign PIX_RGB         = zero_out ? '0 : ram_q[PIXEL_WIDTH-1:0];
   assign unused_ram_bits = ^ram_q[WORD_WIDTH-1:PIXEL_WIDTH];
   disp_fifo_ram #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_WIDTH)
   ) u_ram (
      .clk   (ACLK),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (RDATA),
      .re    (pop),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );
endmodule

// File: tb/tb_disp_pixel_buf.sv
// tb_disp_pixel_buf: scoreboard bench for the display pixel buffer
module tb_disp_pixel_buf;
   localparam int DEPTH = 64;
   logic        ACLK = 1'b0;
   logic        ARST = 1'b1;
   logic [31:0] RDATA = '0;
   logic        RVALID = 1'b0, RREADY = 1'b0, FRAME_START = 1'b0, PIX_REQ = 1'b0;
   logic        FIFO_READY, PIX_VALID, UNDERFLOW;
   logic [23:0] PIX_RGB;
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
   logic [15:0] UNDERFLOW_CNT;
`endif
   int checks = 0, errors = 0;
   logic [23:0] mq[$];
   logic [23:0] sb[$];

   disp_pixel_buf #(.FIFO_DEPTH(64), .BURST_WORDS(32)) dut (
      .ACLK(ACLK), .ARST(ARST), .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
      .FIFO_READY(FIFO_READY), .FRAME_START(FRAME_START), .PIX_REQ(PIX_REQ),
      .PIX_RGB(PIX_RGB), .PIX_VALID(PIX_VALID), .UNDERFLOW(UNDERFLOW)
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
      , .UNDERFLOW_CNT(UNDERFLOW_CNT)
`endif
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // drive one cycle, update the reference FIFO, queue expected pixels for pops
   task automatic cycle(input logic rv, input logic rr, input logic [23:0] pix, input logic req, input logic fs);
      logic do_push, do_pop;
      RVALID = rv; RREADY = rr; RDATA = {8'($urandom), pix}; PIX_REQ = req; FRAME_START = fs;
      do_push = rv && rr && !fs && mq.size() < DEPTH;
      do_pop  = req && !fs && mq.size() > 0;
      if (fs) mq.delete();
      if (do_pop) sb.push_back(mq.pop_front());
      if (do_push) mq.push_back(pix);
      @(posedge ACLK); #1;
      RVALID = 0; RREADY = 0; PIX_REQ = 0; FRAME_START = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge ACLK);
      #1;
      checks++;
      if ({FIFO_READY, PIX_VALID, UNDERFLOW, PIX_RGB} !== 27'h0) begin
         errors++; $display("FAIL reset_outputs: got %h, expected 0", {FIFO_READY, PIX_VALID, UNDERFLOW, PIX_RGB});
      end
      ARST = 0;
      #1;
      checks++;
      if (FIFO_READY !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b, expected 0", FIFO_READY); end
      @(posedge ACLK); #1;
      checks++;
      if ({FIFO_READY, PIX_VALID, UNDERFLOW} !== 3'b100) begin
         errors++; $display("FAIL reset_release: got %b, expected 100", {FIFO_READY, PIX_VALID, UNDERFLOW});
      end
   endtask

   task automatic test_burst_order();
      logic [23:0] exp;
      for (int i = 0; i < 32; i++) cycle(1, 1, 24'(i), 0, 0);
      checks++;
      if (FIFO_READY !== 1'b1) begin errors++; $display("FAIL burst_ready: got %b, expected 1", FIFO_READY); end
      for (int i = 0; i < 32; i++) begin
         cycle(0, 0, 0, 1, 0);
         exp = sb.pop_front();
         checks++;
         if ({PIX_VALID, PIX_RGB} !== {1'b1, exp}) begin
            errors++; $display("FAIL burst_pix[%0d]: got v=%b %h, expected v=1 %h", i, PIX_VALID, PIX_RGB, exp);
         end
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({PIX_VALID, PIX_RGB} !== {1'b0, 24'h00001F}) begin
         errors++; $display("FAIL idle_hold: got v=%b %h, expected v=0 00001f", PIX_VALID, PIX_RGB);
      end
   endtask

   task automatic test_ready_threshold();
      logic [23:0] exp;
      for (int i = 0; i < 33; i++) cycle(1, 1, 24'h400 + 24'(i), 0, 0);
      checks++;
      if (FIFO_READY !== 1'b1) begin errors++; $display("FAIL ready_at_33rd: got %b, expected 1", FIFO_READY); end
      cycle(1, 0, 24'hBAD000, 0, 0);
      checks++;
      if (FIFO_READY !== 1'b0) begin errors++; $display("FAIL ready_fall: got %b, expected 0", FIFO_READY); end
      cycle(0, 0, 0, 1, 0);
      exp = sb.pop_front();
      checks++;
      if ({PIX_VALID, PIX_RGB, FIFO_READY} !== {1'b1, exp, 1'b0}) begin
         errors++; $display("FAIL ready_pop: got v=%b %h r=%b, expected v=1 %h r=0", PIX_VALID, PIX_RGB, FIFO_READY, exp);
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (FIFO_READY !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b, expected 1", FIFO_READY); end
      for (int i = 0; i < 32; i++) begin
         cycle(0, 0, 0, 1, 0);
         exp = sb.pop_front();
         checks++;
         if ({PIX_VALID, PIX_RGB} !== {1'b1, exp}) begin
            errors++; $display("FAIL ready_drain[%0d]: got v=%b %h, expected v=1 %h", i, PIX_VALID, PIX_RGB, exp);
         end
      end
   endtask

   task automatic test_wrap();
      logic [23:0] exp;
      for (int i = 0; i < 64; i++) cycle(1, 1, 24'h100 + 24'(i), 0, 0);
      cycle(1, 1, 24'hDEAD01, 0, 0);
      checks++;
      if (FIFO_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", FIFO_READY); end
      for (int i = 0; i < 60; i++) begin
         if (i < 20) cycle(0, 0, 0, 1, 0);
         else if (i < 40) cycle(1, 1, 24'h140 + 24'(i - 20), 1, 0);
         else cycle(1, 1, 24'h154 + 24'(i - 40), 0, 0);
         if (i < 40) begin
            exp = sb.pop_front();
            checks++;
            if ({PIX_VALID, PIX_RGB} !== {1'b1, exp}) begin
               errors++; $display("FAIL wrap_mid[%0d]: got v=%b %h, expected v=1 %h", i, PIX_VALID, PIX_RGB, exp);
            end
         end
      end
      cycle(1, 1, 24'hDEAD02, 0, 0);
      for (int i = 0; i < 64; i++) begin
         cycle(0, 0, 0, 1, 0);
         exp = sb.pop_front();
         checks++;
         if ({PIX_VALID, PIX_RGB} !== {1'b1, exp}) begin
            errors++; $display("FAIL wrap_drain[%0d]: got v=%b %h, expected v=1 %h", i, PIX_VALID, PIX_RGB, exp);
         end
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if ({PIX_VALID, FIFO_READY, UNDERFLOW} !== 3'b010) begin
         errors++; $display("FAIL wrap_end: got %b, expected 010", {PIX_VALID, FIFO_READY, UNDERFLOW});
      end
   endtask

   task automatic test_underflow();
      logic [23:0] exp;
      cycle(0, 0, 0, 1, 0);
      checks++;
      if ({PIX_VALID, PIX_RGB, UNDERFLOW} !== {1'b0, 24'h0, 1'b1}) begin
         errors++; $display("FAIL underflow: got v=%b %h u=%b, expected v=0 000000 u=1", PIX_VALID, PIX_RGB, UNDERFLOW);
      end
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
      checks++;
      if (UNDERFLOW_CNT !== 16'd1) begin errors++; $display("FAIL uf_cnt1: got %0d, expected 1", UNDERFLOW_CNT); end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (UNDERFLOW_CNT !== 16'd2) begin errors++; $display("FAIL uf_cnt2: got %0d, expected 2", UNDERFLOW_CNT); end
`endif
      for (int i = 0; i < 3; i++) cycle(1, 1, 24'h500 + 24'(i), 0, 0);
      checks++;
      if ({UNDERFLOW, PIX_RGB} !== {1'b1, 24'h0}) begin
         errors++; $display("FAIL uf_sticky: got u=%b %h, expected u=1 000000", UNDERFLOW, PIX_RGB);
      end
      cycle(1, 1, 24'h5FF, 1, 1);
      checks++;
      if ({PIX_VALID, UNDERFLOW} !== 2'b00) begin
         errors++; $display("FAIL frame_clear: got %b, expected 00", {PIX_VALID, UNDERFLOW});
      end
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
      checks++;
      if (UNDERFLOW_CNT !== 16'd0) begin errors++; $display("FAIL uf_cnt_clear: got %0d, expected 0", UNDERFLOW_CNT); end
`endif
      cycle(0, 0, 0, 1, 0);
      checks++;
      if ({PIX_VALID, UNDERFLOW, FIFO_READY} !== 3'b011) begin
         errors++; $display("FAIL frame_empty: got %b, expected 011", {PIX_VALID, UNDERFLOW, FIFO_READY});
      end
      cycle(0, 0, 0, 0, 1);
      cycle(1, 1, 24'h777, 0, 0);
      cycle(0, 0, 0, 1, 0);
      exp = sb.pop_front();
      checks++;
      if ({PIX_VALID, PIX_RGB, UNDERFLOW} !== {1'b1, exp, 1'b0}) begin
         errors++; $display("FAIL frame_restart: got v=%b %h u=%b, expected v=1 %h u=0", PIX_VALID, PIX_RGB, UNDERFLOW, exp);
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] exp;
      cycle(0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) cycle(1, 1, 24'h200 + 24'(i), 0, 0);
      cycle(1, 1, 24'h210, 1, 0);
      exp = sb.pop_front();
      checks++;
      if ({PIX_VALID, PIX_RGB, UNDERFLOW} !== {1'b1, exp, 1'b1}) begin
         errors++; $display("FAIL pre_reset: got v=%b %h u=%b, expected v=1 %h u=1", PIX_VALID, PIX_RGB, UNDERFLOW, exp);
      end
      RVALID = 1; RREADY = 1; RDATA = 32'h0000_0211;
      #2;
      ARST = 1;
      #1;
      checks++;
      if ({FIFO_READY, PIX_VALID, UNDERFLOW, PIX_RGB} !== 27'h0) begin
         errors++; $display("FAIL async_reset: got %h, expected 0", {FIFO_READY, PIX_VALID, UNDERFLOW, PIX_RGB});
      end
`ifdef DISP_PIXEL_BUF_UNDERFLOW_CNT_EN
      checks++;
      if (UNDERFLOW_CNT !== 16'd0) begin errors++; $display("FAIL async_cnt: got %0d, expected 0", UNDERFLOW_CNT); end
`endif
      @(posedge ACLK); #1;
      RVALID = 0; RREADY = 0; ARST = 0;
      mq.delete(); sb.delete();
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (FIFO_READY !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, expected 1", FIFO_READY); end
      for (int i = 0; i < 32; i++) cycle(1, 1, 24'h300 + 24'(i), 0, 0);
      for (int i = 0; i < 32; i++) begin
         cycle(0, 0, 0, 1, 0);
         exp = sb.pop_front();
         checks++;
         if ({PIX_VALID, PIX_RGB} !== {1'b1, exp}) begin
            errors++; $display("FAIL post_reset_pix[%0d]: got v=%b %h, expected v=1 %h", i, PIX_VALID, PIX_RGB, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_burst_order();
      test_ready_threshold();
      test_wrap();
      test_underflow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
